seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: Start  input  1  request a division; sampled only in IDLE.
REQ-005 Port: Signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with Start.
REQ-006 Port: A  input  WIDTH  dividend; captured with Start.
REQ-007 Port: B  input  WIDTH  divisor; captured with Start.
REQ-008 Port: Busy  output  1  high from the Start-accept edge until the edge that leaves DONE.
REQ-009 Port: Done  output  1  single-cycle pulse; results valid.
REQ-010 Port: Quotient  output  WIDTH  quotient (LO).
REQ-011 Port: Remainder  output  WIDTH  remainder (HI).
REQ-012 Port: DivByZero  output  1  high with results when captured B was zero.

Function
REQ-013 States SHALL be IDLE, ITER, FIX, DONE; encoding is free.
REQ-014 IDLE with Start=1 SHALL load operand magnitudes, both operands' sign flags, Signed, and zero-divisor flag; clear the partial remainder; load iteration counter = WIDTH-1; go to ITER.
- Magnitude = two's-complement negation when Signed=1 and MSB=1, else unchanged.
REQ-015 ITER SHALL perform one restoring step per cycle:
- Shift {remainder, dividend} left 1.
- Trial-subtract divisor magnitude from the remainder; if non-negative, keep the difference and set quotient LSB=1; else restore and set LSB=0.
REQ-016 ITER SHALL last exactly WIDTH cycles; on counter = 0, go to FIX.
REQ-017 FIX SHALL drive results on its exit edge:
- Quotient: negated if Signed=1 and operand signs differ.
- Remainder: negated if Signed=1 and A was negative.
- Go to DONE.
REQ-018 DONE SHALL assert Done for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be fixed: Start accepted at edge t gives Done=1 in the cycle after edge t+WIDTH+1, independent of operand values.
REQ-020 Quotient, Remainder, DivByZero SHALL hold their values from the FIX edge until the next FIX edge or reset.
REQ-021 Start while Busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-022 Start=1 in the DONE cycle SHALL be ignored; Start in the following IDLE cycle SHALL be accepted, giving back-to-back throughput of one result per WIDTH+3 cycles.
REQ-023 B=0 SHALL complete with normal latency: Quotient = all ones, Remainder = A as captured, DivByZero=1.
REQ-024 Signed overflow (A = most-negative, B = -1) SHALL yield Quotient = most-negative value, Remainder = 0, DivByZero=0.
REQ-025 All arithmetic SHALL be WIDTH+1 bits internally so trial subtraction never loses the borrow; results are truncated to WIDTH.

Reset
REQ-026 RST_N=0 SHALL asynchronously force state IDLE, Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0, and clear all internal registers.
REQ-027 Reset asserted mid-operation SHALL abort it with no Done pulse.
- The first Start after RST_N rises SHALL be handled normally.

Verification
REQ-028 Unsigned A=100, B=7, Start at edge 0:
- Busy=1 from edge 0.
- Done=1 only in the cycle after edge 33.
- Quotient=14, Remainder=2.
REQ-029 Signed A=0xFFFFFFF9 (-7), B=2 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1).
REQ-030 A=5, B=0, either mode -> Quotient=0xFFFFFFFF, Remainder=5, DivByZero=1, Done after 34 edges.
REQ-031 Signed A=0x80000000, B=0xFFFFFFFF -> Quotient=0x80000000, Remainder=0.
- Same operands unsigned -> Quotient=0, Remainder=0x80000000.
REQ-032 Start A=100, B=7, then Start A=9, B=3 at edge 10 -> second Start ignored; result 14/2.
- Start A=9, B=3 in the IDLE cycle after Done -> Quotient=3, Remainder=0.
REQ-033 RST_N=0 at edge 15 of an operation:
- All outputs 0 immediately; no Done pulse.
- After release, A=0xFFFFFFFF, B=1 unsigned -> Quotient=0xFFFFFFFF, Remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, fixed latency.
// Signed operation divides magnitudes and corrects signs in a final FIX cycle.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH:0]   rem, dvs, shifted, diff;
    logic [WIDTH-1:0] dvd, a_mag, b_mag, q_fix, r_fix;
    logic [CW-1:0]    cnt;
    logic             a_neg, b_neg, sgn, dbz;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (Start) nxt = ITER;
            ITER: if (cnt == '0) nxt = FIX;
            FIX:  nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state != IDLE);
        Done = (state == DONE);
    end

    assign a_mag = (Signed && A[WIDTH-1]) ? -A : A;
    assign b_mag = (Signed && B[WIDTH-1]) ? -B : B;

    // Extra MSB keeps the borrow of the trial subtraction visible in diff[WIDTH].
    assign shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    assign diff    = shifted - dvs;

    // Divide-by-zero overrides the quotient; the remainder already reconstructs A.
    assign q_fix = dbz ? '1 : ((sgn && (a_neg ^ b_neg)) ? -dvd : dvd);
    assign r_fix = (sgn && a_neg) ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rem       <= '0;
            dvs       <= '0;
            dvd       <= '0;
            cnt       <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            sgn       <= 1'b0;
            dbz       <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    rem   <= '0;
                    dvd   <= a_mag;
                    dvs   <= {1'b0, b_mag};
                    cnt   <= CW'(WIDTH - 1);
                    a_neg <= A[WIDTH-1];
                    b_neg <= B[WIDTH-1];
                    sgn   <= Signed;
                    dbz   <= (B == '0);
                end
                ITER: begin
                    cnt <= cnt - 1'b1;
                    if (!diff[WIDTH]) begin
                        rem <= diff;
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    Quotient  <= q_fix;
                    Remainder <= r_fix;
                    DivByZero <= dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: results, latency, Start ignoring, reset abort.
module tb_seq_divider;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Start = 1'b0;
    logic        Signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy, Done, DivByZero;
    logic [31:0] Quotient, Remainder;

    int n_run = 0;
    int n_fail = 0;

    seq_divider #(.WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .Signed(Signed), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
        .DivByZero(DivByZero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start is asserted before edge 0 and dropped just after it; operands then change.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Signed = s; A = a; B = b; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0; Signed = ~s;
        chk("busy_accept", {31'd0, Busy}, 32'd1);
    endtask

    // Counts edges after accept until Done; optionally pokes a Start at edge inj.
    task automatic wait_done(input int inj, output int done_edge);
        done_edge = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            if (k == inj) begin
                Start = 1'b1; A = 32'd9; B = 32'd3; Signed = 1'b0;
            end else if (k == inj + 1) begin
                Start = 1'b0;
            end
            if (k < 33) chk("busy_iter", {31'd0, Busy}, 32'd1);
            if (Done) begin
                done_edge = k;
                break;
            end
        end
        chk("done_edge", done_edge, 32'd33);
    endtask

    task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input logic ez);
        int de;
        launch(s, a, b);
        wait_done(0, de);
        chk("quot", Quotient, eq);
        chk("rem", Remainder, er);
        chk("dbz", {31'd0, DivByZero}, {31'd0, ez});
        @(posedge CLK); #1;
        chk("done_pulse", {31'd0, Done}, 32'd0);
        chk("busy_idle", {31'd0, Busy}, 32'd0);
        chk("quot_hold", Quotient, eq);
    endtask

    initial begin
        int de;
        #12;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_quot", Quotient, 32'd0);
        chk("rst_rem", Remainder, 32'd0);
        chk("rst_dbz", {31'd0, DivByZero}, 32'd0);
        @(negedge CLK); RST_N = 1'b1;

        op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        op(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        op(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);

        // Start during ITER is ignored; Start in DONE is ignored, next IDLE accepts.
        launch(1'b0, 32'd100, 32'd7);
        wait_done(10, de);
        chk("ign_quot", Quotient, 32'd14);
        chk("ign_rem", Remainder, 32'd2);
        Start = 1'b1; A = 32'd9; B = 32'd3; Signed = 1'b0;
        @(posedge CLK); #1;
        chk("done_start_ign", {31'd0, Busy}, 32'd0);
        @(posedge CLK); #1;
        Start = 1'b0;
        chk("b2b_accept", {31'd0, Busy}, 32'd1);
        wait_done(0, de);
        chk("b2b_quot", Quotient, 32'd3);
        chk("b2b_rem", Remainder, 32'd0);

        // Reset mid-operation aborts with no Done pulse.
        @(posedge CLK); #1;
        launch(1'b0, 32'd100, 32'd7);
        repeat (14) @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_quot", Quotient, 32'd0);
        chk("abort_rem", Remainder, 32'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 25; k++) begin
                @(posedge CLK); #1;
                if (Done) seen++;
            end
            chk("abort_no_done", seen, 32'd0);
        end
        @(negedge CLK); RST_N = 1'b1;
        op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
